// File: rtl/dose_pkg.sv
// Shared types and constants for the 4-compartment dose scheduler.
package dose_pkg;

  localparam int NUM_COMP        = 4;
  localparam int IDX_W           = 2;
  localparam int TMR_W           = 8;
  localparam int DEF_INTERVAL_W  = 8;
  localparam int DEF_ACK_TIMEOUT = 4;
  localparam int DEF_NOTIFY_LEN  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALARM  = 2'd1,
    NOTIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [NUM_COMP-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_COMP-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/dose_timer.sv
// Per-compartment free-running interval countdown; strobes due on the tick that expires it.
module dose_timer #(
  parameter int INTERVAL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  wr,
  input  logic [INTERVAL_W-1:0] wr_interval,
  output logic                  due
);

  logic [INTERVAL_W-1:0] interval_r;
  logic [INTERVAL_W-1:0] cnt_r;

  // A configuration write on this compartment masks a coincident expiry.
  assign due = tick & ~wr & (interval_r != {INTERVAL_W{1'b0}})
             & (cnt_r <= INTERVAL_W'(1));

  // Interval register and countdown; reload on expiry keeps the period exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      interval_r <= {INTERVAL_W{1'b0}};
      cnt_r      <= {INTERVAL_W{1'b0}};
    end else if (wr) begin
      interval_r <= wr_interval;
      cnt_r      <= wr_interval;
    end else if (tick && (interval_r != {INTERVAL_W{1'b0}})) begin
      cnt_r <= due ? interval_r : (cnt_r - INTERVAL_W'(1));
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/dose_scheduler.sv
// Dose scheduler: four interval timers, round-robin arbitration of due requests,
// and an alarm / acknowledge / escalate sequencer driving the front panel.
module dose_scheduler
  import dose_pkg::*;
#(
  parameter int INTERVAL_W  = DEF_INTERVAL_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int NOTIFY_LEN  = DEF_NOTIFY_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_sel,
  input  logic [INTERVAL_W-1:0] cfg_interval,
  input  logic [NUM_COMP-1:0]   button,
  output logic [NUM_COMP-1:0]   shouldEat,
  output logic [NUM_COMP-1:0]   notify,
  output logic [NUM_COMP-1:0]   overrun,
  output logic                  busy
);

  logic [NUM_COMP-1:0] due_s;
  logic [NUM_COMP-1:0] wr_s;
  logic [NUM_COMP-1:0] clr_s;
  logic [NUM_COMP-1:0] pending_r;
  logic [NUM_COMP-1:0] overrun_r;
  logic [IDX_W-1:0]    ptr_r;
  logic [IDX_W-1:0]    grant_r;
  logic [IDX_W-1:0]    grant_s;
  logic [IDX_W-1:0]    arb_idx_s;
  logic                grant_vld_s;
  logic [TMR_W-1:0]    timer_r;
  state_t              state_r;
  state_t              state_s;
  logic [NUM_COMP-1:0] should_eat_s;
  logic [NUM_COMP-1:0] notify_s;
  logic                busy_s;
  logic [NUM_COMP-1:0] should_eat_r;
  logic [NUM_COMP-1:0] notify_r;
  logic                busy_r;

  for (genvar i = 0; i < NUM_COMP; i++) begin : g_timer
    assign wr_s[i] = cfg_we & (cfg_sel == IDX_W'(i));

    dose_timer #(.INTERVAL_W(INTERVAL_W)) u_timer (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .wr          (wr_s[i]),
      .wr_interval (cfg_interval),
      .due         (due_s[i])
    );
  end

  // Round-robin search over pending, starting at the pointer; 2-bit index wraps mod 4.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = ptr_r;
    arb_idx_s   = ptr_r;
    for (int k = 0; k < NUM_COMP; k++) begin
      arb_idx_s = ptr_r + IDX_W'(k);
      if (!grant_vld_s && pending_r[arb_idx_s]) begin
        grant_vld_s = 1'b1;
        grant_s     = arb_idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign clr_s = (state_r == IDLE && grant_vld_s) ? onehot(grant_s) : {NUM_COMP{1'b0}};

  // Pending requests and sticky overrun; a served request that comes due again is not an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NUM_COMP{1'b0}};
      overrun_r <= {NUM_COMP{1'b0}};
    end else begin
      pending_r <= ((pending_r & ~clr_s) | due_s) & ~wr_s;
      overrun_r <= overrun_r | (due_s & pending_r & ~clr_s);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; acknowledge takes priority over a coincident timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_vld_s) state_s = ALARM;
        else             state_s = IDLE;
      end
      ALARM: begin
        if (button[grant_r])                                         state_s = DONE;
        else if (tick && (timer_r == TMR_W'(ACK_TIMEOUT - 1)))       state_s = NOTIFY;
        else                                                         state_s = ALARM;
      end
      NOTIFY: begin
        if (button[grant_r])                                         state_s = DONE;
        else if (tick && (timer_r == TMR_W'(NOTIFY_LEN - 1)))        state_s = DONE;
        else                                                         state_s = NOTIFY;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Grant latch, arbitration pointer and per-state tick counter (cleared on every transition).
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r <= {IDX_W{1'b0}};
      ptr_r   <= {IDX_W{1'b0}};
      timer_r <= {TMR_W{1'b0}};
    end else begin
      if (state_r == IDLE && grant_vld_s) begin
        grant_r <= grant_s;
        ptr_r   <= grant_s + IDX_W'(1);
      end else begin
        grant_r <= grant_r;
        ptr_r   <= ptr_r;
      end
      if (state_s != state_r) begin
        timer_r <= {TMR_W{1'b0}};
      end else if (tick && (state_r == ALARM || state_r == NOTIFY)) begin
        timer_r <= timer_r + TMR_W'(1);
      end else begin
        timer_r <= timer_r;
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    should_eat_s = {NUM_COMP{1'b0}};
    notify_s     = {NUM_COMP{1'b0}};
    busy_s       = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      ALARM: begin
        should_eat_s = onehot(grant_r);
        busy_s       = 1'b1;
      end
      NOTIFY: begin
        should_eat_s = onehot(grant_r);
        notify_s     = onehot(grant_r);
        busy_s       = 1'b1;
      end
      DONE: begin
        busy_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      should_eat_r <= {NUM_COMP{1'b0}};
      notify_r     <= {NUM_COMP{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      should_eat_r <= should_eat_s;
      notify_r     <= notify_s;
      busy_r       <= busy_s;
    end
  end

  assign shouldEat = should_eat_r;
  assign notify    = notify_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed and randomized bench for dose_scheduler against a behavioural reference model.
module tb_dose_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_interval = 8'd0;
  logic [3:0] button = 4'd0;
  logic [3:0] shouldEat;
  logic [3:0] notify;
  logic [3:0] overrun;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam int PH_IDLE = 0, PH_ALARM = 1, PH_NOTIFY = 2, PH_DONE = 3;

  // Reference model state.
  int  m_iv[4];
  int  m_cnt[4];
  bit  m_pend[4];
  bit  m_ov[4];
  int  m_ptr = 0;
  int  m_g = 0;
  int  m_ph = PH_IDLE;
  int  m_wait = 0;
  bit [3:0] e_se = 4'd0;
  bit [3:0] e_nt = 4'd0;
  bit       e_busy = 1'b0;

  dose_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_interval(cfg_interval), .button(button), .shouldEat(shouldEat),
    .notify(notify), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock of the behavioural model, using the inputs sampled at this edge.
  task automatic model_update();
    bit due[4];
    bit one_hot_g[4];
    bit [3:0] one;
    int grant;
    one = 4'b0001;
    grant = -1;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_iv[i] = 0; m_cnt[i] = 0; m_pend[i] = 1'b0; m_ov[i] = 1'b0;
      end
      m_ptr = 0; m_g = 0; m_ph = PH_IDLE; m_wait = 0;
      e_se = 4'd0; e_nt = 4'd0; e_busy = 1'b0;
    end else begin
      e_se   = (m_ph == PH_ALARM || m_ph == PH_NOTIFY) ? (one << m_g) : 4'd0;
      e_nt   = (m_ph == PH_NOTIFY) ? (one << m_g) : 4'd0;
      e_busy = (m_ph != PH_IDLE);
      for (int i = 0; i < 4; i++) begin
        bit wr;
        wr = cfg_we && (int'(cfg_sel) == i);
        due[i] = tick && !wr && m_iv[i] != 0 && m_cnt[i] == 1;
        if (wr) begin
          m_iv[i] = int'(cfg_interval); m_cnt[i] = int'(cfg_interval);
        end else if (tick && m_iv[i] != 0) begin
          m_cnt[i] = (m_cnt[i] == 1) ? m_iv[i] : m_cnt[i] - 1;
        end
      end
      case (m_ph)
        PH_IDLE: begin
          for (int k = 0; k < 4; k++)
            if (grant < 0 && m_pend[(m_ptr + k) % 4]) grant = (m_ptr + k) % 4;
          if (grant >= 0) begin
            m_g = grant; m_ptr = (grant + 1) % 4; m_ph = PH_ALARM; m_wait = 0;
          end
        end
        PH_ALARM: begin
          if (button[m_g]) m_ph = PH_DONE;
          else if (tick) begin
            m_wait++;
            if (m_wait == 4) begin m_ph = PH_NOTIFY; m_wait = 0; end
          end
        end
        PH_NOTIFY: begin
          if (button[m_g]) m_ph = PH_DONE;
          else if (tick) begin
            m_wait++;
            if (m_wait == 2) m_ph = PH_DONE;
          end
        end
        default: m_ph = PH_IDLE;
      endcase
      for (int i = 0; i < 4; i++) begin
        one_hot_g[i] = (i == grant);
        if (cfg_we && int'(cfg_sel) == i) m_pend[i] = 1'b0;
        else if (due[i]) begin
          if (m_pend[i] && !one_hot_g[i]) m_ov[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (one_hot_g[i]) m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    bit [3:0] e_ov;
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < 4; i++) e_ov[i] = m_ov[i];
    check("shouldEat", shouldEat, e_se);
    check("notify", notify, e_nt);
    check("overrun", overrun, e_ov);
    check("busy", {3'b000, busy}, {3'b000, e_busy});
  endtask

  task automatic cfg(input int sel, input int iv);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_interval = 8'(iv);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic rst_dut();
    rst = 1'b1; step(); rst = 1'b0; step();
  endtask

  initial begin
    bit [3:0] exp4;
    // 1: reset dominates concurrent cfg write and buttons
    rst = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_interval = 8'd5; button = 4'hF; tick = 1'b1;
    step(); step();
    check("t1_se", shouldEat, 4'd0);
    check("t1_nt", notify, 4'd0);
    check("t1_busy", {3'b000, busy}, 4'd0);
    rst = 1'b0; cfg_we = 1'b0; button = 4'd0;
    for (int k = 0; k < 6; k++) begin tick = (k % 2 == 0); step(); end
    tick = 1'b0;
    check("t1_idle_se", shouldEat, 4'd0);
    check("t1_idle_busy", {3'b000, busy}, 4'd0);

    // 2: timeout escalation on compartment 0
    rst_dut();
    cfg(0, 3);
    for (int t = 0; t < 3; t++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    check("t2_pre", shouldEat, 4'd0);
    tick = 1'b1; step();
    check("t2_alarm", shouldEat, 4'b0001);
    check("t2_busy", {3'b000, busy}, 4'b0001);
    for (int t = 0; t < 3; t++) begin tick = 1'b0; step(); tick = 1'b1; step(); end
    check("t2_pre_notify", notify, 4'd0);
    tick = 1'b0; step();
    check("t2_notify", notify, 4'b0001);
    check("t2_notify_se", shouldEat, 4'b0001);
    tick = 1'b1; step(); tick = 1'b0; step(); tick = 1'b1; step(); tick = 1'b0; step();
    check("t2_done_se", shouldEat, 4'd0);
    check("t2_done_nt", notify, 4'd0);
    check("t2_done_busy", {3'b000, busy}, 4'b0001);
    step();
    check("t2_gap_busy", {3'b000, busy}, 4'd0);

    // 3: acknowledge on compartment 1, foreign button ignored
    rst_dut();
    cfg(1, 2);
    tick = 1'b1; step(); tick = 1'b0; step(); tick = 1'b1; step(); tick = 1'b0; step();
    button = 4'b1000; step();
    check("t3_alarm", shouldEat, 4'b0010);
    step();
    check("t3_foreign_btn", shouldEat, 4'b0010);
    button = 4'b0010; step();
    button = 4'd0; step();
    check("t3_ack_se", shouldEat, 4'd0);
    check("t3_ack_nt", notify, 4'd0);
    check("t3_ack_busy", {3'b000, busy}, 4'b0001);

    // 4: simultaneous due, round-robin order then wrap
    rst_dut();
    for (int i = 0; i < 4; i++) cfg(i, 1);
    tick = 1'b1; step(); tick = 1'b0;
    for (int n = 0; n < 4; n++) begin
      exp4 = 4'b0001 << n;
      for (int k = 0; k < 20; k++) begin
        if (shouldEat != 4'd0) break;
        step();
      end
      check("t4_order", shouldEat, exp4);
      button = exp4; step(); button = 4'd0; step();
    end
    tick = 1'b1; step(); tick = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (shouldEat != 4'd0) break;
      step();
    end
    check("t4_wrap", shouldEat, 4'b0001);

    // 5: overrun on compartment 2 while compartment 0 is being alarmed
    rst_dut();
    cfg(0, 1);
    tick = 1'b1; step(); tick = 1'b0; step();
    cfg(0, 0);
    cfg(2, 1);
    for (int t = 0; t < 12; t++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    check("t5_overrun", overrun, 4'b0100);
    rst_dut();
    check("t5_overrun_rst", overrun, 4'd0);

    // 6: reset mid-NOTIFY, then cfg write coinciding with due tick
    cfg(0, 1);
    for (int k = 0; k < 40; k++) begin
      if (notify != 4'd0) break;
      tick = (k % 2 == 0); step();
    end
    tick = 1'b0;
    check("t6_notify", notify, 4'b0001);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_rst_se", shouldEat, 4'd0);
    check("t6_rst_nt", notify, 4'd0);
    check("t6_rst_busy", {3'b000, busy}, 4'd0);
    cfg(1, 2);
    tick = 1'b1; step();
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_interval = 8'd3; tick = 1'b1; step();
    cfg_we = 1'b0; tick = 1'b0; step(); step();
    check("t6_wr_wins_se", shouldEat, 4'd0);
    check("t6_wr_wins_busy", {3'b000, busy}, 4'd0);
    tick = 1'b1; step(); tick = 1'b0; step(); tick = 1'b1; step(); tick = 1'b0; step();
    check("t6_restart_se", shouldEat, 4'd0);
    tick = 1'b1; step(); tick = 1'b0; step(); step();
    check("t6_restart_alarm", shouldEat, 4'b0010);

    // Randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < 1500; c++) begin
      tick         = ($urandom_range(0, 2) == 0);
      cfg_we       = ($urandom_range(0, 15) == 0);
      cfg_sel      = 2'($urandom_range(0, 3));
      cfg_interval = 8'($urandom_range(0, 6));
      button       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      rst          = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; cfg_we = 1'b0; tick = 1'b0; button = 4'd0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
